// File: rtl/timer_pkg.sv
// timer_pkg: shared register map, CTRL bit positions and FSM state encoding for timer blocks
package timer_pkg;
    localparam logic [1:0] ADDR_COMPARE = 2'd0;
    localparam logic [1:0] ADDR_PERIOD  = 2'd1;
    localparam logic [1:0] ADDR_CTRL    = 2'd2;
    localparam int CTRL_EN  = 0;
    localparam int CTRL_PER = 1;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIRED = 2'd2
    } state_t;
endpackage

// File: rtl/timer_reached.sv
// timer_reached: wrap-safe "count has reached target" test, valid for targets up to half the range ahead
module timer_reached #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic [WIDTH-1:0] i_target,
    output logic             o_reached
);
    logic [WIDTH-1:0] w_diff;
    assign w_diff    = i_count - i_target;
    assign o_reached = ~w_diff[WIDTH-1];
endmodule

// File: rtl/timer_compare.sv
// timer_compare: compare/interrupt unit on the free-running count; define TIMER_PERIODIC_EN for auto-reload
module timer_compare
    import timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_count,
    input  logic             i_reg_we,
    input  logic [1:0]       i_reg_addr,
    input  logic [WIDTH-1:0] i_reg_wdata,
    input  logic             i_irq_ack,
    output logic             o_irq,
    output logic [1:0]       o_state
);
    state_t           r_state;
    logic [WIDTH-1:0] r_target;
    logic             r_enable;
    logic             r_irq;
    logic             w_reached;
    logic             w_ctrl_wr;
    logic             w_cmp_wr;
    logic             w_reload;
    logic [WIDTH-1:0] w_reload_target;

    assign w_ctrl_wr = i_reg_we && i_reg_addr == ADDR_CTRL;
    assign w_cmp_wr  = i_reg_we && i_reg_addr == ADDR_COMPARE;

`ifdef TIMER_PERIODIC_EN
    logic [WIDTH-1:0] r_period;
    logic             r_periodic;

    assign w_reload        = r_periodic;
    assign w_reload_target = r_target + r_period;

    // PERIOD register and periodic mode bit, both plain register writes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_period   <= '0;
            r_periodic <= 1'b0;
        end else begin
            if (i_reg_we && i_reg_addr == ADDR_PERIOD)
                r_period <= i_reg_wdata;
            if (w_ctrl_wr)
                r_periodic <= i_reg_wdata[CTRL_PER];
        end
    end
`else
    assign w_reload        = 1'b0;
    assign w_reload_target = r_target;
`endif

    timer_reached #(.WIDTH(WIDTH)) u_reached (
        .i_count  (i_count),
        .i_target (r_target),
        .o_reached(w_reached)
    );

    // Control FSM: a CTRL write overrides everything, then fire on reach, then ack handling; a
    // COMPARE write always lands last so it beats a reload in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_irq    <= 1'b0;
            r_enable <= 1'b0;
            r_target <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_enable <= i_reg_wdata[CTRL_EN];
                r_state  <= i_reg_wdata[CTRL_EN] ? ST_ARMED : ST_IDLE;
                r_irq    <= 1'b0;
            end else if (r_state == ST_ARMED && r_enable && w_reached) begin
                r_state <= ST_FIRED;
                r_irq   <= 1'b1;
            end else if (r_state == ST_FIRED && i_irq_ack) begin
                r_state  <= w_reload ? ST_ARMED : ST_IDLE;
                r_irq    <= 1'b0;
                r_enable <= w_reload;
                if (w_reload)
                    r_target <= w_reload_target;
            end
            if (w_cmp_wr)
                r_target <= i_reg_wdata;
        end
    end

    assign o_irq   = r_irq;
    assign o_state = r_state;
endmodule

// File: tb/tb_timer_compare.sv
// tb_timer_compare: directed test of timer_compare at WIDTH=32 and WIDTH=8 against a behavioural model
module tb_timer_compare;
`ifdef TIMER_PERIODIC_EN
    localparam bit PER = 1'b1;
`else
    localparam bit PER = 1'b0;
`endif
    localparam int IDLE = 0, ARMED = 1, FIRED = 2;
    localparam logic [1:0] A_CMP = 2'd0, A_PER = 2'd1, A_CTRL = 2'd2;

    typedef struct {
        logic [31:0] t;
        logic [31:0] p;
        bit          per;
        int          s;
    } mdl_t;

    logic        clk;
    logic        rst  [2];
    logic        we   [2];
    logic [1:0]  addr [2];
    logic [31:0] wd   [2];
    logic [31:0] cnt  [2];
    logic        ack  [2];
    logic        irq  [2];
    logic [1:0]  st   [2];
    mdl_t        m    [2];
    int          n_chk = 0;
    int          n_fail = 0;

    timer_compare #(.WIDTH(32)) u32 (
        .clk(clk), .reset(rst[0]), .i_count(cnt[0]), .i_reg_we(we[0]), .i_reg_addr(addr[0]),
        .i_reg_wdata(wd[0]), .i_irq_ack(ack[0]), .o_irq(irq[0]), .o_state(st[0])
    );
    timer_compare #(.WIDTH(8)) u8 (
        .clk(clk), .reset(rst[1]), .i_count(cnt[1][7:0]), .i_reg_we(we[1]), .i_reg_addr(addr[1]),
        .i_reg_wdata(wd[1][7:0]), .i_irq_ack(ack[1]), .o_irq(irq[1]), .o_state(st[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Next model state from the rules: reached means target is at most half the range behind count
    function automatic mdl_t step(input int k, input mdl_t c);
        logic [31:0] msk = (k == 1) ? 32'hff : 32'hffff_ffff;
        mdl_t n = c;
        if (rst[k]) begin
            n = '{t: 0, p: 0, per: 0, s: IDLE};
            return n;
        end
        if (we[k] && addr[k] == A_CTRL) begin
            n.per = PER && wd[k][1];
            n.s   = wd[k][0] ? ARMED : IDLE;
        end else if (c.s == ARMED && ((cnt[k] - c.t) & msk) <= (msk >> 1)) begin
            n.s = FIRED;
        end else if (c.s == FIRED && ack[k]) begin
            if (PER && c.per) begin
                n.s = ARMED;
                n.t = (c.t + c.p) & msk;
            end else begin
                n.s = IDLE;
            end
        end
        if (we[k] && addr[k] == A_CMP) n.t = wd[k] & msk;
        if (we[k] && addr[k] == A_PER && PER) n.p = wd[k] & msk;
        return n;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) m[k] <= step(k, m[k]);
    end

    task automatic cmp_all();
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (st[k] !== 2'(m[k].s) || irq[k] !== (m[k].s == FIRED)) begin
                n_fail++;
                $display("FAIL model_dut%0d at %0t: state=%0d irq=%b, model state=%0d irq=%b",
                         k, $time, st[k], irq[k], m[k].s, m[k].s == FIRED);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    task automatic chk(input int k, input string nm, input logic ei, input int es);
        n_chk++;
        if (irq[k] !== ei || st[k] !== 2'(es) || m[k].s != es) begin
            n_fail++;
            $display("FAIL %s: dut irq=%b state=%0d model state=%0d, expected irq=%b state=%0d",
                     nm, irq[k], st[k], m[k].s, ei, es);
        end
    endtask

    task automatic wr(input int k, input logic [1:0] a, input logic [31:0] d);
        we[k] = 1'b1; addr[k] = a; wd[k] = d;
        tick();
        we[k] = 1'b0;
    endtask

    initial begin
        logic f;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; we[k] = 1'b0; addr[k] = '0; wd[k] = '0; cnt[k] = '0; ack[k] = 1'b0;
        end
        tick();
        rst[0] = 1'b0; rst[1] = 1'b0;
        chk(0, "reset32", 1'b0, IDLE);
        chk(1, "reset8", 1'b0, IDLE);

        cnt[0] = 90;
        wr(0, A_CMP, 100);
        wr(0, A_CTRL, 1);
        chk(0, "oneshot_arm", 1'b0, ARMED);
        for (int c = 91; c <= 105; c++) begin
            cnt[0] = c;
            tick();
            chk(0, "oneshot_fire", c >= 100, c >= 100 ? FIRED : ARMED);
        end
        ack[0] = 1'b1; tick(); ack[0] = 1'b0;
        chk(0, "oneshot_ack", 1'b0, IDLE);
        tick();
        chk(0, "oneshot_stays_idle", 1'b0, IDLE);

        cnt[0] = 40;
        wr(0, A_CMP, 50);
        wr(0, A_PER, 20);
        wr(0, A_CTRL, 3);
        for (int c = 41; c <= 100; c++) begin
            cnt[0] = c;
            ack[0] = (c == 51 || c == 71 || c == 91);
            tick();
            ack[0] = 1'b0;
            f = PER ? (c == 50 || c == 70 || c == 90) : (c == 50);
            chk(0, "periodic", f, f ? FIRED : ((PER || c < 51) ? ARMED : IDLE));
        end
        wr(0, A_CTRL, 0);
        chk(0, "periodic_off", 1'b0, IDLE);

        cnt[0] = 1000;
        wr(0, A_PER, 500);
        wr(0, A_CMP, 900);
        wr(0, A_CTRL, 3);
        chk(0, "late_arm", 1'b0, ARMED);
        tick();
        chk(0, "late_fire", 1'b1, FIRED);
        ack[0] = 1'b1; wr(0, A_CTRL, 0); ack[0] = 1'b0;
        chk(0, "ack_ctrl0", 1'b0, IDLE);
        wr(0, A_CTRL, 3);
        chk(0, "rearm", 1'b0, ARMED);
        tick();
        chk(0, "target_kept", 1'b1, FIRED);
        ack[0] = 1'b1; wr(0, A_CTRL, 3); ack[0] = 1'b0;
        chk(0, "ack_ctrl3", 1'b0, ARMED);
        tick();
        chk(0, "ack_ctrl3_no_reload", 1'b1, FIRED);
        ack[0] = 1'b1; wr(0, A_CMP, 5000); ack[0] = 1'b0;
        chk(0, "ack_cmp", 1'b0, PER ? ARMED : IDLE);
        tick();
        chk(0, "ack_cmp_wait", 1'b0, PER ? ARMED : IDLE);
        cnt[0] = 5000;
        tick();
        chk(0, "ack_cmp_fire", PER, PER ? FIRED : IDLE);

        wr(0, A_CTRL, 0);
        wr(0, A_CTRL, 1);
        tick();
        chk(0, "pre_reset_fired", 1'b1, FIRED);
        rst[0] = 1'b1; tick(); rst[0] = 1'b0;
        chk(0, "reset_in_fired", 1'b0, IDLE);
        ack[0] = 1'b1; tick(); ack[0] = 1'b0;
        tick();
        chk(0, "ack_after_reset", 1'b0, IDLE);

        cnt[0] = 6000;
        wr(0, A_PER, 0);
        wr(0, A_CMP, 6000);
        wr(0, A_CTRL, 3);
        tick();
        chk(0, "p0_fire", 1'b1, FIRED);
        ack[0] = 1'b1; tick(); ack[0] = 1'b0;
        chk(0, "p0_ack", 1'b0, PER ? ARMED : IDLE);
        tick();
        chk(0, "p0_refire", PER, PER ? FIRED : IDLE);
        wr(0, A_CTRL, 0);

        cnt[1] = 250;
        wr(1, A_CMP, 4);
        wr(1, A_CTRL, 1);
        chk(1, "wrap_arm", 1'b0, ARMED);
        for (int i = 1; i <= 14; i++) begin
            cnt[1] = (250 + i) % 256;
            tick();
            chk(1, "wrap", i >= 10, i >= 10 ? FIRED : ARMED);
        end
        ack[1] = 1'b1; tick(); ack[1] = 1'b0;
        chk(1, "wrap_ack", 1'b0, IDLE);

        cnt[1] = 100;
        wr(1, A_CMP, 200);
        wr(1, A_CTRL, 1);
        ack[1] = 1'b1; tick(); ack[1] = 1'b0;
        chk(1, "ack_in_armed", 1'b0, ARMED);
        wr(1, A_CMP, 50);
        chk(1, "cmp_write_next", 1'b0, ARMED);
        tick();
        chk(1, "cmp_write_fire", 1'b1, FIRED);
        ack[1] = 1'b1; tick(); ack[1] = 1'b0;

        cnt[1] = 120;
        wr(1, A_CMP, 120);
        wr(1, A_CTRL, 1);
        wr(1, A_CMP, 200);
        chk(1, "cmp_at_reach", 1'b1, FIRED);
        ack[1] = 1'b1; tick(); ack[1] = 1'b0;
        chk(1, "cmp_at_reach_ack", 1'b0, IDLE);
        wr(1, A_CTRL, 1);
        tick();
        chk(1, "new_target_used", 1'b0, ARMED);
        wr(1, A_CTRL, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/timer_compare.md
# timer_compare

Compare/interrupt unit that consumes the running count from the free-running cycle counter and raises a CPU interrupt when that count reaches a programmed target. It sits directly downstream of the counter and is programmed through a small register-write port on the CPU I/O bus. It supports one-shot and, optionally, periodic auto-reload operation, with wrap-safe comparison.

## Interface
- WIDTH, 32, width of count, compare and period values (matches counter width)
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- count  in  WIDTH  free-running count value from the upstream counter
- reg_we  in  1  register write strobe, one cycle per write
- reg_addr  in  2  register select: 0 COMPARE, 1 PERIOD, 2 CTRL, 3 reserved (writes ignored)
- reg_wdata  in  WIDTH  write data
- irq_ack  in  1  interrupt acknowledge, one-cycle pulse from CPU
- irq  out  1  level interrupt request
- state  out  2  current FSM state: 0 IDLE, 1 ARMED, 2 FIRED

## Operation
- Registers:
  - target (COMPARE)
  - period (PERIOD)
  - ctrl: bit0 enable, bit1 periodic; upper bits ignored.
- Reset: target=0, period=0, enable=0, periodic=0, state=IDLE, irq=0.
- Reached condition: MSB of (count - target) mod 2^WIDTH is 0. Any target up to 2^(WIDTH-1)-1 ahead of count is valid; wrap of count through zero is handled.
- FSM:
  - IDLE: irq=0. A CTRL write with enable=1 moves to ARMED next cycle.
  - ARMED: irq=0. If reached, move to FIRED and set irq=1.
  - FIRED: irq held at 1 until irq_ack.
    - On ack with periodic=1: target <= target + period (mod 2^WIDTH), go to ARMED.
    - On ack with periodic=0: enable <= 0, go to IDLE.
- A CTRL write with enable=0 in any state goes to IDLE with irq=0 on the next cycle.
- A COMPARE write in ARMED takes effect for the comparison on the following cycle.
- Reload target is target + period, not count + period. If the reloaded target is already past, the unit refires on the next evaluation; there is no skipping of missed periods.
- period=0 in periodic mode: the unit refires one cycle after every ack. This is legal, not an error.
- irq_ack outside FIRED is ignored.

## Timing
- Fire latency: count==target presented in cycle n gives state=FIRED and irq=1 in cycle n+1. Comparison is combinational on count; the result is registered.
- Ack: irq_ack in cycle n gives irq=0 in cycle n+1. Periodic re-arm evaluates from cycle n+1, so the earliest refire is irq=1 in cycle n+2.
- A register write in cycle n is visible in cycle n+1.
- Simultaneous events:
  - CTRL write together with irq_ack in FIRED: the CTRL write wins. The enable value decides the next state; no reload occurs.
  - COMPARE write together with irq_ack in periodic FIRED: the written value becomes target; no add occurs.
  - COMPARE write in the same cycle the old target is reached: FIRED is taken, and the new target applies after the next ack.
- Reset mid-operation returns all state to reset values on the next edge, including dropping irq.

## Configuration
- TIMER_PERIODIC_EN defined: the PERIOD register, ctrl bit1 and reload on ack exist as described.
- TIMER_PERIODIC_EN undefined:
  - No period register or adder.
  - Writes to addr 1 and ctrl bit1 are ignored.
  - Every ack goes to IDLE with enable cleared (one-shot only).

## Structure
- Shared package timer_pkg holds:
  - register address constants (ADDR_COMPARE=0, ADDR_PERIOD=1, ADDR_CTRL=2)
  - CTRL bit indices
  - state encoding (ST_IDLE, ST_ARMED, ST_FIRED).
- One natural sub-module: timer_reached, a combinational wrap-safe compare (count, target -> reached), reusable by later multi-channel timers.

## Test plan
- One-shot: target=100, CTRL=1, count passes 100 -> irq=1 one cycle after count=100. Ack -> irq=0, state=IDLE, enable=0.
- Periodic: target=50, period=20, CTRL=3 -> fires one cycle after count 50, 70 and 90, given an ack after each fire. No fire at any other count.
- Wrap: WIDTH=8, count starts at 250, target=4 -> no fire before wrap; fire one cycle after count=4.
- Late target: count=1000, target=900, enable -> fires on the first ARMED cycle (target treated as past).
- Disable during FIRED, with a simultaneous ack and CTRL=0 -> irq=0 next cycle, state=IDLE, target unchanged (no reload).
- Reset asserted in FIRED -> irq=0 and state=IDLE next cycle. Later acks do nothing until re-enabled.
